// File: rtl/clock_strobe_gen_pkg.sv
// Shared constants and helpers for the core clock/strobe tree.
// CPU rate codes, reference AY accumulator increments and rate-match logic.
package clock_pkg;

    localparam logic [1:0] CPU_DIV8 = 2'b00;
    localparam logic [1:0] CPU_DIV4 = 2'b01;
    localparam logic [1:0] CPU_DIV2 = 2'b10;

    // Increments for ACC_W = 16 at a 28 MHz master clock.
    localparam logic [15:0] AY_1M75   = 16'd4096;
    localparam logic [15:0] AY_1M7734 = 16'd4151;
    localparam logic [15:0] AY_3M5    = 16'd8192;
    localparam logic [15:0] AY_3M546  = 16'd8302;

    // Code 11 is an alias of /2 and is reported as 10.
    function automatic logic [1:0] norm_cpu_sel(input logic [1:0] sel);
        return (sel == 2'b11) ? CPU_DIV2 : sel;
    endfunction

    function automatic logic cpu_rate_hit(input logic [2:0] cnt, input logic [1:0] act);
        case (act)
            CPU_DIV8: return (cnt == 3'd7);
            CPU_DIV4: return (cnt[1:0] == 2'b11);
            default:  return cnt[0];
        endcase
    endfunction

endpackage

// File: rtl/clock_strobe_gen_if.sv
// Control inputs and strobe outputs of clock_strobe_gen.
// Strobes are single-cycle enables; there is no valid/ready handshake on this bus.
interface clock_strobe_gen_if #(
    parameter int PHASES  = 4,
    parameter int NUM_NCO = 2,
    parameter int ACC_W   = 16
);
    logic [1:0]               cpu_sel;
    logic [NUM_NCO-1:0]       nco_en;
    logic [NUM_NCO*ACC_W-1:0] nco_inc;

    logic                     f0;
    logic                     f1;
    logic                     h0;
    logic                     h1;
    logic [PHASES-1:0]        c;
    logic                     cpu_stb;
    logic [1:0]               cpu_sel_act;
    logic [NUM_NCO-1:0]       nco_clk;
    logic [NUM_NCO-1:0]       nco_stb;

    modport master (
        output cpu_sel, nco_en, nco_inc,
        input  f0, f1, h0, h1, c, cpu_stb, cpu_sel_act, nco_clk, nco_stb
    );

    modport slave (
        input  cpu_sel, nco_en, nco_inc,
        output f0, f1, h0, h1, c, cpu_stb, cpu_sel_act, nco_clk, nco_stb
    );
endinterface

// File: rtl/clock_strobe_gen_nco.sv
// Single phase-accumulator audio clock: MSB is the output clock,
// nco_stb is a one-cycle pulse registered one cycle after the MSB rises.
module clock_nco #(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [ACC_W-1:0] inc,
    output logic             nco_clk,
    output logic             nco_stb
);

    logic [ACC_W-1:0] acc;
    logic             msb_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            msb_q   <= 1'b0;
            nco_stb <= 1'b0;
        end else begin
            if (en) begin
                acc <= acc + inc;
            end
            // msb_q tracks the MSB even while disabled so a held level never re-fires.
            msb_q   <= acc[ACC_W-1];
            nco_stb <= acc[ACC_W-1] & ~msb_q;
        end
    end

    assign nco_clk = acc[ACC_W-1];

endmodule

// File: rtl/clock_strobe_gen.sv
// Top of the core clock tree: f/h divider phases, one-hot phase ring,
// glitch-free selectable CPU clock-enable and NUM_NCO audio NCO channels.
module clock_strobe_gen
    import clock_pkg::*;
#(
    parameter int PHASES  = 4,
    parameter int NUM_NCO = 2,
    parameter int ACC_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    clock_strobe_gen_if.slave   bus
);

    logic [1:0]        f;
    logic [1:0]        h;
    logic [PHASES-1:0] c;
    logic [2:0]        cnt;
    logic              cpu_stb_q;
    logic [1:0]        cpu_sel_act_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f             <= 2'b01;
            h             <= 2'b01;
            c             <= {{(PHASES-1){1'b0}}, 1'b1};
            cnt           <= 3'd0;
            cpu_stb_q     <= 1'b0;
            cpu_sel_act_q <= CPU_DIV8;
        end else begin
            f   <= ~f;
            if (f[1]) begin
                h <= ~h;
            end
            c   <= {c[PHASES-2:0], c[PHASES-1]};
            cnt <= cnt + 3'd1;
            // cnt == 7 matches every rate, so swapping the rate there never makes a runt.
            cpu_stb_q <= cpu_rate_hit(cnt, cpu_sel_act_q);
            if (cnt == 3'd7) begin
                cpu_sel_act_q <= norm_cpu_sel(bus.cpu_sel);
            end
        end
    end

    assign bus.f0          = f[0];
    assign bus.f1          = f[1];
    assign bus.h0          = h[0];
    assign bus.h1          = h[1];
    assign bus.c           = c;
    assign bus.cpu_stb     = cpu_stb_q;
    assign bus.cpu_sel_act = cpu_sel_act_q;

    for (genvar i = 0; i < NUM_NCO; i++) begin : g_nco
        clock_nco #(
            .ACC_W (ACC_W)
        ) u_nco (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (bus.nco_en[i]),
            .inc     (bus.nco_inc[i*ACC_W +: ACC_W]),
            .nco_clk (bus.nco_clk[i]),
            .nco_stb (bus.nco_stb[i])
        );
    end

endmodule

// File: tb/tb_clock_strobe_gen.sv
// Self-checking bench for clock_strobe_gen: phase tree, CPU strobe rate
// switching, NCO period/count, hold and mid-run reset.
module tb_clock_strobe_gen;
    import clock_pkg::*;

    localparam int PHASES  = 4;
    localparam int NUM_NCO = 2;
    localparam int ACC_W   = 16;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    clock_strobe_gen_if #(.PHASES(PHASES), .NUM_NCO(NUM_NCO), .ACC_W(ACC_W)) bus ();

    clock_strobe_gen #(
        .PHASES  (PHASES),
        .NUM_NCO (NUM_NCO),
        .ACC_W   (ACC_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          edge_n   = 0;
    logic [31:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic do_reset(input logic [1:0] sel);
        rst_n       = 1'b0;
        bus.cpu_sel = sel;
        tick();
        rst_n  = 1'b1;
        edge_n = 0;
    endtask

    function automatic logic [7:0] phase_vec();
        return {bus.f1, bus.f0, bus.h1, bus.h0, bus.c};
    endfunction

    task automatic test_reset();
        logic [1:0] ef, eh;
        logic [3:0] ec;
        logic [31:0] e;
        rst_n       = 1'b0;
        bus.cpu_sel = 2'b00;
        bus.nco_en  = '0;
        bus.nco_inc = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (phase_vec() !== 8'b01_01_0001) begin
                n_fail++;
                $display("FAIL reset_phase cyc%0d got %b want 01010001", i, phase_vec());
            end
        end
        n_checks++;
        if ({bus.cpu_stb, bus.cpu_sel_act, bus.nco_clk, bus.nco_stb} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_misc got stb=%b act=%b nclk=%b nstb=%b want all 0",
                     bus.cpu_stb, bus.cpu_sel_act, bus.nco_clk, bus.nco_stb);
        end
        rst_n  = 1'b1;
        edge_n = 0;
        for (int k = 1; k <= 4; k++) begin
            ef = (k % 2 == 1) ? 2'b10 : 2'b01;
            eh = ((k / 2) % 2 == 1) ? 2'b10 : 2'b01;
            ec = 4'b0001 << (k % PHASES);
            exp_q.push_back({24'd0, ef, eh, ec});
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({24'd0, phase_vec()} !== e) begin
                n_fail++;
                $display("FAIL release_phase edge%0d got %b want %b", k, phase_vec(), e[7:0]);
            end
        end
    endtask

    // Pops one expected gap per observed strobe; leftovers mean missing strobes.
    task automatic run_cpu_gaps(input int n_edges, input int switch_edge, input logic [1:0] new_sel,
                                input int act_edge, input logic [1:0] act_before, input logic [1:0] act_after);
        int last = 0;
        int gap;
        logic [31:0] e;
        for (int k = 1; k <= n_edges; k++) begin
            tick();
            if (bus.cpu_stb === 1'b1) begin
                gap = edge_n - last;
                last = edge_n;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL cpu_gap unexpected strobe at edge %0d gap %0d", edge_n, gap);
                end else begin
                    e = exp_q.pop_front();
                    if (gap !== int'(e)) begin
                        n_fail++;
                        $display("FAIL cpu_gap edge%0d got %0d want %0d", edge_n, gap, e);
                    end
                end
            end
            if (edge_n == act_edge - 1) begin
                n_checks++;
                if (bus.cpu_sel_act !== act_before) begin
                    n_fail++;
                    $display("FAIL cpu_act_before got %b want %b", bus.cpu_sel_act, act_before);
                end
            end
            if (edge_n == act_edge) begin
                n_checks++;
                if (bus.cpu_sel_act !== act_after) begin
                    n_fail++;
                    $display("FAIL cpu_act_after got %b want %b", bus.cpu_sel_act, act_after);
                end
            end
            if (edge_n == switch_edge) bus.cpu_sel = new_sel;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL cpu_missing got %0d unseen strobes want 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_cpu_switch();
        do_reset(2'b00);
        // /8 strobes at 8,16,24; switch at cnt=2 lands on boundary 24, then /4.
        exp_q = '{32'd8, 32'd8, 32'd8, 32'd4, 32'd4, 32'd4, 32'd4};
        run_cpu_gaps(40, 18, 2'b01, 24, 2'b00, 2'b01);
    endtask

    task automatic test_cpu_sel11();
        do_reset(2'b11);
        exp_q = '{32'd8, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2};
        run_cpu_gaps(20, 0, 2'b11, 8, 2'b00, 2'b10);
    endtask

    task automatic test_nco_period();
        int highs = 0;
        int bad_lvl = 0;
        logic [31:0] e;
        do_reset(2'b00);
        bus.nco_inc = {AY_3M546, AY_3M5};
        bus.nco_en  = 2'b01;
        exp_q = '{32'd5, 32'd13, 32'd21, 32'd29};
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (bus.nco_clk[0]) highs++;
            if (bus.nco_clk[0] !== ((k % 8) >= 4)) bad_lvl++;
            if (bus.nco_stb[0] === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL nco_stb0 unexpected pulse at edge %0d", k);
                end else begin
                    e = exp_q.pop_front();
                    if (k !== int'(e)) begin
                        n_fail++;
                        $display("FAIL nco_stb0 pulse edge got %0d want %0d", k, e);
                    end
                end
            end
            if (bus.nco_clk[1] !== 1'b0 || bus.nco_stb[1] !== 1'b0) begin
                n_checks++;
                n_fail++;
                $display("FAIL nco1_disabled edge%0d got clk=%b stb=%b want 0 0",
                         k, bus.nco_clk[1], bus.nco_stb[1]);
            end
        end
        n_checks++;
        if (highs != 16 || bad_lvl != 0) begin
            n_fail++;
            $display("FAIL nco0_duty got highs=%0d badlvl=%0d want 16 0", highs, bad_lvl);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL nco0_missing got %0d unseen pulses want 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_nco_count();
        int cnt0 = 0;
        int cnt1 = 0;
        logic [31:0] e;
        do_reset(2'b00);
        bus.nco_inc = {AY_1M7734, AY_1M75};
        bus.nco_en  = 2'b11;
        exp_q.push_back(32'd4096);
        exp_q.push_back(32'd4151);
        // Two extra edges cover the registered-strobe latency.
        for (int k = 0; k < 65538; k++) begin
            tick();
            if (bus.nco_stb[0] === 1'b1) cnt0++;
            if (bus.nco_stb[1] === 1'b1) cnt1++;
        end
        e = exp_q.pop_front();
        n_checks++;
        if (cnt0 !== int'(e)) begin
            n_fail++;
            $display("FAIL nco0_count got %0d want %0d", cnt0, e);
        end
        e = exp_q.pop_front();
        n_checks++;
        if (cnt1 !== int'(e)) begin
            n_fail++;
            $display("FAIL nco1_count got %0d want %0d", cnt1, e);
        end
    endtask

    task automatic test_nco_hold_reset();
        int bad = 0;
        int pulses = 0;
        do_reset(2'b00);
        bus.nco_inc = {16'd0, 16'h2000};
        bus.nco_en  = 2'b01;
        repeat (6) tick();
        n_checks++;
        if (bus.nco_clk[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL nco_pre_hold got %b want 1", bus.nco_clk[0]);
        end
        bus.nco_en = 2'b00;
        repeat (10) begin
            tick();
            if (bus.nco_clk[0] !== 1'b1 || bus.nco_stb[0] !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL nco_hold got %0d bad cycles want 0", bad);
        end
        // Accumulator resumes from 0xC000: E000, 0000, 2000, 4000, 6000, 8000.
        bus.nco_en = 2'b01;
        exp_q = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1};
        for (int k = 1; k <= 6; k++) begin
            logic [31:0] e;
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({31'd0, bus.nco_clk[0]} !== e) begin
                n_fail++;
                $display("FAIL nco_resume step%0d got %b want %0d", k, bus.nco_clk[0], e);
            end
        end
        bus.nco_inc = '0;
        repeat (5) begin
            tick();
            if (bus.nco_stb[0] === 1'b1) pulses++;
            if (bus.nco_clk[0] !== 1'b1) bad++;
        end
        n_checks++;
        if (pulses != 1 || bad != 0) begin
            n_fail++;
            $display("FAIL nco_inc_zero got pulses=%0d bad=%0d want 1 0", pulses, bad);
        end
        bus.nco_inc = {16'h1111, 16'h2000};
        bus.nco_en  = 2'b11;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({phase_vec(), bus.cpu_stb, bus.cpu_sel_act, bus.nco_clk, bus.nco_stb} !==
            {8'b01_01_0001, 7'b0}) begin
            n_fail++;
            $display("FAIL midrun_reset got ph=%b stb=%b act=%b nclk=%b nstb=%b want 01010001 0 00 00 00",
                     phase_vec(), bus.cpu_stb, bus.cpu_sel_act, bus.nco_clk, bus.nco_stb);
        end
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_cpu_switch();
        test_cpu_sel11();
        test_nco_period();
        test_nco_count();
        test_nco_hold_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
